// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed anode scan for common-anode 7-segment digits with
// per-frame input snapshot, leading-zero blanking and an anode guard interval.
module seg7_scan #(
    parameter int NDIG  = 8,
    parameter int DIV   = 50000,
    parameter int GUARD = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [4*NDIG-1:0]    data_i,
    input  logic [NDIG-1:0]      dots_i,
    input  logic [NDIG-1:0]      ens_i,
    input  logic                 lzb_i,
    output logic [3:0]           din_o,
    output logic                 en_o,
    output logic                 dot_o,
    output logic [NDIG-1:0]      ndigsel_o,
    output logic                 frame_o
);
    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(NDIG);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] sd_q, sd_d;
    logic [NDIG-1:0]   sp_q, sp_d, se_q, se_d;
    logic [NDIG-1:0]   nz, nsel_d, nsel_q;
    logic [3:0]        din_d, din_q;
    logic              wrap, snap, acc, vis_d, en_q, dot_q, frame_q;

    always_comb begin
        wrap = cnt_q == CW'(DIV - 1);
        snap = wrap && idx_q == IW'(NDIG - 1);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        idx_d = !wrap ? idx_q : snap ? '0 : idx_q + 1'b1;
        sd_d = snap ? data_i : sd_q;
        sp_d = snap ? dots_i : sp_q;
        se_d = snap ? ens_i : se_q;
        // nz[i]: some digit from i up to the most significant one is non-zero
        acc = 1'b0;
        nz = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            acc = acc | (|sd_d[4*i +: 4]);
            nz[i] = acc;
        end
        vis_d = se_d[idx_d] && (!lzb_i || idx_d == '0 || nz[idx_d]);
        din_d = sd_d[{idx_d, 2'b00} +: 4];
        nsel_d = (cnt_d >= CW'(GUARD)) ? ~(NDIG'(1) << idx_d) : '1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            idx_q   <= IW'(NDIG - 1);
            sd_q    <= '0;
            sp_q    <= '0;
            se_q    <= '0;
            din_q   <= '0;
            en_q    <= 1'b0;
            dot_q   <= 1'b0;
            nsel_q  <= '1;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sd_q    <= sd_d;
            sp_q    <= sp_d;
            se_q    <= se_d;
            nsel_q  <= nsel_d;
            frame_q <= snap;
            // decoder inputs move only at slot boundaries, while anodes are off
            if (wrap) begin
                din_q <= din_d;
                en_q  <= vis_d;
                dot_q <= vis_d & sp_d[idx_d];
            end
        end
    end

    assign din_o     = din_q;
    assign en_o      = en_q;
    assign dot_o     = dot_q;
    assign ndigsel_o = nsel_q;
    assign frame_o   = frame_q;
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed checks plus a cycle-by-cycle reference model built from
// elapsed time since reset release.
module tb_seg7_scan;
    localparam int NDIG = 4, DIV = 8, GUARD = 2;

    logic        clk = 0, rst = 1, lzb = 0;
    logic [15:0] data = 16'h1234;
    logic [3:0]  dots = 4'b0100, ens = 4'hF;
    logic [3:0]  din, nsel;
    logic        en, dot, frame;
    int          tests = 0, fails = 0;

    int          n = 0, m_p = 0, m_dg = NDIG - 1;
    logic [15:0] m_sd = 0;
    logic [3:0]  m_sp = 0, m_se = 0, e_din = 0, e_nsel;
    logic        e_en = 0, e_dot = 0, e_frame, vis;

    seg7_scan #(.NDIG(NDIG), .DIV(DIV), .GUARD(GUARD)) dut (
        .clk_i(clk), .rst_i(rst), .data_i(data), .dots_i(dots), .ens_i(ens),
        .lzb_i(lzb), .din_o(din), .en_o(en), .dot_o(dot), .ndigsel_o(nsel),
        .frame_o(frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: slot and digit follow from cycles elapsed since reset release
    always @(posedge clk) begin
        if (rst) begin
            n = 0; m_p = 0; m_dg = NDIG - 1;
            m_sd = 0; m_sp = 0; m_se = 0; e_din = 0; e_en = 0; e_dot = 0;
        end else begin
            n++;
            m_p = n % DIV;
            m_dg = (NDIG - 1 + n / DIV) % NDIG;
            if (m_p == 0 && m_dg == 0) begin
                m_sd = data; m_sp = dots; m_se = ens;
            end
            if (m_p == 0) begin
                vis = m_se[m_dg] && !(lzb && m_dg != 0 && (m_sd >> (4 * m_dg)) == 0);
                e_din = m_sd[4*m_dg +: 4];
                e_en = vis;
                e_dot = vis && m_sp[m_dg];
            end
        end
        e_nsel = (n > 0 && m_p >= GUARD) ? ~(4'b1 << m_dg) : 4'hF;
        e_frame = n > 0 && m_p == 0 && m_dg == 0;
        #1;
        chk("m_din", din, e_din);
        chk("m_en", en, e_en);
        chk("m_dot", dot, e_dot);
        chk("m_nsel", nsel, e_nsel);
        chk("m_frame", frame, e_frame);
    end

    task automatic at_slot(input int d);
        bit ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = !rst && m_dg == d && m_p == GUARD;
        end
        if (!ok) chk("slot_timeout", 0, 1);
    endtask

    task automatic wait_frame();
        bit ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = frame;
        end
        if (!ok) chk("frame_timeout", 0, 1);
    endtask

    task automatic slot_lit(input string name, input int d, input int x_din,
                            input int x_en, input int x_dot);
        at_slot(d);
        chk({name, "_din"}, din, x_din);
        chk({name, "_en"}, en, x_en);
        chk({name, "_dot"}, dot, x_dot);
        chk({name, "_nsel"}, nsel, 4'hF & ~(4'b1 << d));
    endtask

    initial begin
        int k;
        logic [3:0] lits [4];
        lits[0] = 4'h4; lits[1] = 4'h3; lits[2] = 4'h2; lits[3] = 4'h1;
        repeat (3) @(negedge clk);
        chk("rst_din", din, 0); chk("rst_en", en, 0); chk("rst_dot", dot, 0);
        chk("rst_nsel", nsel, 4'hF); chk("rst_frame", frame, 0);
        rst = 0;
        for (k = 1; k <= 20; k++) begin
            @(posedge clk); #2;
            if (k == GUARD) begin
                chk("start_nsel", nsel, 4'b0111);
                chk("start_en", en, 0);
            end
            if (frame) break;
        end
        chk("start_frame_cycle", k, DIV);

        for (int d = 0; d < NDIG; d++) slot_lit("scan", d, lits[d], 1, d == 2);
        wait_frame();
        k = 0;
        do begin @(negedge clk); k++; end while (!frame && k < 100);
        chk("frame_period", k, NDIG * DIV);

        at_slot(1);
        repeat (3 - GUARD) @(negedge clk);
        data = 16'h9999;
        slot_lit("snap2", 2, 2, 1, 1);
        slot_lit("snap3", 3, 1, 1, 0);
        slot_lit("snap0", 0, 9, 1, 0);

        lzb = 1; data = 16'h0070; dots = 4'h0;
        wait_frame();
        slot_lit("lzb70_0", 0, 0, 1, 0);
        slot_lit("lzb70_1", 1, 7, 1, 0);
        slot_lit("lzb70_2", 2, 0, 0, 0);
        slot_lit("lzb70_3", 3, 0, 0, 0);
        data = 16'h0000;
        wait_frame();
        for (int d = 0; d < NDIG; d++) slot_lit("lzb00", d, 0, d == 0, 0);
        lzb = 0;
        wait_frame();
        for (int d = 0; d < NDIG; d++) slot_lit("nolzb", d, 0, 1, 0);

        data = 16'h1234; ens = 4'b1011; dots = 4'hF;
        wait_frame();
        for (int d = 0; d < NDIG; d++) slot_lit("ens", d, lits[d], d != 2, d != 2);

        at_slot(1);
        #2 rst = 1;
        #1;
        chk("arst_din", din, 0); chk("arst_en", en, 0); chk("arst_dot", dot, 0);
        chk("arst_nsel", nsel, 4'hF); chk("arst_frame", frame, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        wait_frame();
        slot_lit("post", 0, 4, 1, 1);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
